autotype_sequencer: RTL and testbench



---
 rtl/autotype_pkg.sv | 32 +++
 rtl/autotype_tick.sv | 35 +++
 rtl/autotype_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_autotype_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/autotype_pkg.sv
// Shared definitions for the scripted key-press player: opcodes,
// script field positions and controller state encoding.
package autotype_pkg;

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_PRESS = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int KEY_MSB  = 4;
    localparam int KEY_LSB  = 0;
    localparam int WAIT_MSB = 5;
    localparam int WAIT_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/autotype_tick.sv
// Timing-tick prescaler: pulses tick_o once every TICK_CYCLES clocks,
// restarting from zero whenever clear_i is high.
module autotype_tick #(
    parameter int TICK_CYCLES = 8388608
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/autotype_sequencer.sv
// Scripted reset/key player driven from an external script ROM.
// Define AUTOTYPE_USER_ABORT_EN to add user_activity as an extra abort source.
module autotype_sequencer
    import autotype_pkg::*;
#(
    parameter int N_KEYS      = 3,
    parameter int SCRIPT_AW   = 4,
    parameter int TICK_CYCLES = 8388608,
    parameter int HOLD_TICKS  = 1,
    parameter int GAP_TICKS   = 1,
    parameter int AUTO_START  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
`ifdef AUTOTYPE_USER_ABORT_EN
    input  logic                 user_activity,
`endif
    output logic [SCRIPT_AW-1:0] script_addr,
    input  logic [7:0]           script_data,
    output logic                 n_reset_out,
    output logic [N_KEYS-1:0]    keys,
    output logic                 busy,
    output logic                 done,
    output logic                 bad_op
);

    localparam int TW = max3(6, $clog2(HOLD_TICKS + 1), $clog2(GAP_TICKS + 1));

    state_t                state_q, state_d;
    logic [SCRIPT_AW-1:0]  addr_q, addr_d;
    logic [1:0]            op_q, op_d;
    logic [4:0]            idx_q, idx_d;
    logic [TW-1:0]         dur_q, dur_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [N_KEYS-1:0]     keys_q, keys_d;
    logic                  nres_q, nres_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bad_q, bad_d;
    logic                  auto_q;
    logic                  abort_w;
    logic                  tick;
    logic                  pclr;
    logic                  step;
    logic                  seg_end;
    logic                  gap_end;

`ifdef AUTOTYPE_USER_ABORT_EN
    assign abort_w = abort | (user_activity & busy_q);
`else
    assign abort_w = abort;
`endif

    assign pclr    = (state_q == S_DECODE);
    assign seg_end = tick && (tcnt_q == dur_q);
    assign gap_end = tick && (tcnt_q == TW'(GAP_TICKS - 1));

    autotype_tick #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear_i(pclr),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= OP_END;
            idx_q   <= '0;
            dur_q   <= '0;
            tcnt_q  <= '0;
            keys_q  <= '0;
            nres_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
            auto_q  <= (AUTO_START != 0);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            tcnt_q  <= tcnt_d;
            keys_q  <= keys_d;
            nres_q  <= nres_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
            auto_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (script_data[OP_MSB:OP_LSB] == OP_END) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (seg_end) begin
                    if (op_q == OP_WAIT || GAP_TICKS == 0) begin
                        step = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The last ROM entry ends the script instead of wrapping to 0.
        if (step) begin
            if (addr_q == '1) begin
                state_d = S_DONE;
            end else begin
                state_d = S_FETCH;
                addr_d  = addr_q + 1'b1;
            end
        end
        if (abort_w) begin
            addr_d  = addr_q;
            state_d = (state_q == S_IDLE) ? S_IDLE : S_DONE;
        end
    end

    always_comb begin
        op_d   = op_q;
        idx_d  = idx_q;
        dur_d  = dur_q;
        tcnt_d = tcnt_q;
        bad_d  = bad_q;
        if (state_q == S_DECODE) begin
            op_d  = script_data[OP_MSB:OP_LSB];
            idx_d = script_data[KEY_MSB:KEY_LSB];
            if (op_d == OP_WAIT) begin
                dur_d = TW'(script_data[WAIT_MSB:WAIT_LSB]);
            end else begin
                dur_d = TW'(HOLD_TICKS - 1);
            end
            if (op_d == OP_PRESS && int'(idx_d) >= N_KEYS && state_d == S_ACTIVE) begin
                bad_d = 1'b1;
            end
        end
        if (state_q == S_DECODE || state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        keys_d = '0;
        nres_d = 1'b1;
        if (state_d == S_ACTIVE) begin
            if (op_d == OP_PRESS) begin
                for (int i = 0; i < N_KEYS; i++) begin
                    keys_d[i] = (idx_d == 5'(i));
                end
            end
            if (op_d == OP_RESET) begin
                nres_d = 1'b0;
            end
        end
        busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_ACTIVE) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    assign script_addr = addr_q;
    assign n_reset_out = nres_q;
    assign keys        = keys_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bad_op      = bad_q;

endmodule

// File: tb/tb_autotype_sequencer.sv
// Bench for autotype_sequencer: one auto-starting instance and one
// manual-start instance share a script ROM; cycle traces come from a script model.
module tb_autotype_sequencer;

    localparam int T    = 4;
    localparam int HOLD = 1;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       user_act = 1'b0;
    logic [3:0] addr;
    logic [7:0] sdata;
    logic       nres;
    logic [2:0] keys;
    logic       busy;
    logic       done;
    logic       bad;

    logic       reset0 = 1'b1;
    logic       start0 = 1'b0;
    logic [3:0] addr0;
    logic [7:0] sdata0;
    logic       nres0;
    logic [2:0] keys0;
    logic       busy0;
    logic       done0;
    logic       bad0;

    logic [7:0] rom [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sdata  <= rom[addr];
        sdata0 <= rom[addr0];
    end

    autotype_sequencer #(
        .N_KEYS(3), .SCRIPT_AW(4), .TICK_CYCLES(T),
        .HOLD_TICKS(HOLD), .GAP_TICKS(GAP), .AUTO_START(1)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef AUTOTYPE_USER_ABORT_EN
        .user_activity(user_act),
`endif
        .script_addr(addr), .script_data(sdata), .n_reset_out(nres),
        .keys(keys), .busy(busy), .done(done), .bad_op(bad)
    );

    autotype_sequencer #(
        .N_KEYS(3), .SCRIPT_AW(4), .TICK_CYCLES(T),
        .HOLD_TICKS(HOLD), .GAP_TICKS(GAP), .AUTO_START(0)
    ) u_dut0 (
        .clk(clk), .reset(reset0), .start(start0), .abort(1'b0),
`ifdef AUTOTYPE_USER_ABORT_EN
        .user_activity(1'b0),
`endif
        .script_addr(addr0), .script_data(sdata0), .n_reset_out(nres0),
        .keys(keys0), .busy(busy0), .done(done0), .bad_op(bad0)
    );

    typedef struct {
        logic [2:0] keys;
        logic       nres;
        logic       busy;
        logic       done;
        logic       bad;
        logic [3:0] addr;
    } smp_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] keys;
        logic       nres;
        logic       bad;
        int         cyc;
    } vec_t;

    smp_t exp_q[$];
    logic model_bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic rep(input int n, input logic [2:0] k, input logic nr,
                       input logic b, input logic d, input logic [3:0] a);
        smp_t s;
        for (int i = 0; i < n; i++) begin
            s.keys = k; s.nres = nr; s.busy = b; s.done = d;
            s.bad = model_bad; s.addr = a;
            exp_q.push_back(s);
        end
    endtask

    // Expected per-cycle trace of a whole script run, starting at its first FETCH.
    task automatic build(input logic bad_in);
        logic [7:0] d;
        int idx;
        int last;
        exp_q.delete();
        model_bad = bad_in;
        last = 0;
        for (int a = 0; a < 16; a++) begin
            d = rom[a];
            last = a;
            rep(2, 3'b000, 1'b1, 1'b1, 1'b0, 4'(a));
            if (d[7:6] == 2'b00) break;
            if (d[7:6] == 2'b01) begin
                idx = int'(d[4:0]);
                if (idx >= 3) model_bad = 1'b1;
                rep(T * HOLD, (idx < 3) ? 3'(1 << idx) : 3'b000, 1'b1, 1'b1, 1'b0, 4'(a));
                rep(T * GAP, 3'b000, 1'b1, 1'b1, 1'b0, 4'(a));
            end else if (d[7:6] == 2'b10) begin
                rep(T * HOLD, 3'b000, 1'b0, 1'b1, 1'b0, 4'(a));
                rep(T * GAP, 3'b000, 1'b1, 1'b1, 1'b0, 4'(a));
            end else begin
                rep((int'(d[5:0]) + 1) * T, 3'b000, 1'b1, 1'b1, 1'b0, 4'(a));
            end
        end
        rep(4, 3'b000, 1'b1, 1'b0, 1'b1, 4'(last));
    endtask

    task automatic play(input string name);
        smp_t e;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            e = exp_q[i];
            checks++;
            if (keys !== e.keys || nres !== e.nres || busy !== e.busy ||
                done !== e.done || bad !== e.bad || addr !== e.addr) begin
                errors++;
                $display("FAIL %s cyc %0d: got k=%b nr=%b b=%b d=%b bad=%b a=%0d expected k=%b nr=%b b=%b d=%b bad=%b a=%0d",
                         name, i, keys, nres, busy, done, bad, addr,
                         e.keys, e.nres, e.busy, e.done, e.bad, e.addr);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("rst_keys", 32'(keys), 0);
        chk("rst_nres", 32'(nres), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bad", 32'(bad), 0);
        chk("rst_addr", 32'(addr), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = a0; rom[1] = a1; rom[2] = a2; rom[3] = a3; rom[4] = a4;
    endtask

    vec_t vt[11];

    initial begin
        int n;
        logic carry;
        vt[0]  = '{8'h41, 3'b010, 1'b1, 1'b0, 11};
        vt[1]  = '{8'h42, 3'b100, 1'b1, 1'b0, 11};
        vt[2]  = '{8'h40, 3'b001, 1'b1, 1'b0, 11};
        vt[3]  = '{8'h80, 3'b000, 1'b0, 1'b0, 11};
        vt[4]  = '{8'hBF, 3'b000, 1'b0, 1'b0, 11};
        vt[5]  = '{8'hC2, 3'b000, 1'b1, 1'b0, 15};
        vt[6]  = '{8'hC0, 3'b000, 1'b1, 1'b0, 7};
        vt[7]  = '{8'h45, 3'b000, 1'b1, 1'b1, 11};
        vt[8]  = '{8'h7F, 3'b000, 1'b1, 1'b1, 11};
        vt[9]  = '{8'h00, 3'b000, 1'b1, 1'b0, 1};
        vt[10] = '{8'h3F, 3'b000, 1'b1, 1'b0, 1};
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        // single-opcode scripts: first active-cycle outputs and run length
        for (int v = 0; v < 11; v++) begin
            load(vt[v].data, 8'h00, 8'h00, 8'h00, 8'h00);
            do_reset();
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_keys", v), 32'(keys), 32'(vt[v].keys));
            chk($sformatf("vec%0d_nres", v), 32'(nres), 32'(vt[v].nres));
            chk($sformatf("vec%0d_bad", v), 32'(bad), 32'(vt[v].bad));
            n = 1;
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("vec%0d_len", v), 32'(n), 32'(vt[v].cyc));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 0);
        end

        // demo script with auto start
        load(8'h80, 8'h41, 8'h42, 8'h40, 8'h00);
        do_reset();
        build(1'b0);
        play("demo");

        // out-of-range key: flag survives DONE and restart
        load(8'h45, 8'h41, 8'h00, 8'h00, 8'h00);
        do_reset();
        build(1'b0);
        play("badop");
        start = 1'b1;
        build(1'b1);
        play("badop_restart");

        // full ROM of presses, no END
        for (int i = 0; i < 16; i++) rom[i] = 8'h40 | 8'(i % 3);
        do_reset();
        build(1'b0);
        play("full_rom");

        // abort during the hold of PRESS 1, then abort+start, then replay
        load(8'h42, 8'h41, 8'h40, 8'h00, 8'h00);
        do_reset();
        repeat (14) @(negedge clk);
        chk("abort_pre_keys", 32'(keys), 32'b010);
        chk("abort_pre_addr", 32'(addr), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_keys", 32'(keys), 0);
        chk("abort_done", 32'(done), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_nres", 32'(nres), 1);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_start_done", 32'(done), 1);
        chk("abort_start_busy", 32'(busy), 0);
        start = 1'b1;
        build(1'b0);
        play("abort_replay");

        // manual-start instance: idle after reset, async reset mid-GAP
        load(8'h41, 8'h80, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        reset0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle0_busy", 32'(busy0), 0);
        chk("idle0_done", 32'(done0), 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("run0_busy", 32'(busy0), 1);
        repeat (13) @(negedge clk);
        chk("run0_nres", 32'(nres0), 0);
        repeat (4) @(negedge clk);
        chk("gap0_addr", 32'(addr0), 1);
        chk("gap0_busy", 32'(busy0), 1);
        #2 reset0 = 1'b1;
        #1;
        chk("async0_busy", 32'(busy0), 0);
        chk("async0_addr", 32'(addr0), 0);
        chk("async0_nres", 32'(nres0), 1);
        chk("async0_keys", 32'(keys0), 0);
        @(negedge clk);
        reset0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle0b_busy", 32'(busy0), 0);
        chk("idle0b_done", 32'(done0), 0);
        chk("idle0b_bad", 32'(bad0), 0);

`ifdef AUTOTYPE_USER_ABORT_EN
        load(8'h41, 8'h42, 8'h00, 8'h00, 8'h00);
        do_reset();
        repeat (4) @(negedge clk);
        user_act = 1'b1;
        @(negedge clk);
        user_act = 1'b0;
        chk("user_abort_done", 32'(done), 1);
        chk("user_abort_busy", 32'(busy), 0);
        chk("user_abort_keys", 32'(keys), 0);
`endif

        // randomized scripts against the trace model
        carry = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                n = int'($urandom_range(0, 9));
                if (n == 0) rom[i] = 8'($urandom_range(0, 63));
                else if (n <= 4) rom[i] = 8'h40 | 8'($urandom_range(0, 3));
                else if (n <= 6) rom[i] = 8'h80 | 8'($urandom_range(0, 63));
                else rom[i] = 8'hC0 | 8'($urandom_range(0, 3));
            end
            if (r == 0 || (r % 3) == 0) begin
                do_reset();
                build(1'b0);
            end else begin
                start = 1'b1;
                build(carry);
            end
            play($sformatf("rand%0d", r));
            carry = model_bad;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
